mor1kx_load_unit_cappuccino: RTL and testbench

MOR1KX_LOAD_UNIT_CAPPUCCINO -- requirements
Module: mor1kx_load_unit_cappuccino

---
 rtl/mor1kx_load_unit_cappuccino.sv | 154 +++++++++++++++
 tb/tb_mor1kx_load_unit_cappuccino.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_load_unit_cappuccino.sv
// Load unit: issues one word-aligned bus read per load, then lane-selects and
// extends the big-endian return data; reports misalignment and bus errors.
module mor1kx_load_unit_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] addr_i,
  input  logic [1:0]                      length_i,
  input  logic                            sext_i,
  input  logic                            flush_i,
  output logic                            dbus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_o,
  input  logic                            dbus_ack_i,
  input  logic                            dbus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_o,
  output logic                            lsu_valid_o,
  output logic                            busy_o,
  output logic                            except_align_o,
  output logic                            except_buserr_o
);

  localparam int W = OPTION_OPERAND_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, ABORT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   adr_q, adr_d;
  logic [W-1:0]   result_q, result_d;
  logic [1:0]     off_q, off_d;
  logic [1:0]     len_q, len_d;
  logic           sext_q, sext_d;
  logic           valid_q, valid_d;
  logic           align_q, align_d;
  logic           buserr_q, buserr_d;
  logic           misaligned;
  logic           resp;

  function automatic logic [W-1:0] extend(input logic [15:0] v,
                                          input logic is_byte,
                                          input logic sext);
    logic sign;
    sign   = sext & (is_byte ? v[7] : v[15]);
    extend = {W{sign}};
    if (is_byte) extend[7:0]  = v[7:0];
    else         extend[15:0] = v;
  endfunction

  // Big-endian lanes: byte offset 0 lives in the most significant byte.
  function automatic logic [W-1:0] align_data(input logic [W-1:0] dat,
                                              input logic [1:0] off,
                                              input logic [1:0] len,
                                              input logic sext);
    logic [7:0] b;
    case (off)
      2'd0:    b = dat[31:24];
      2'd1:    b = dat[23:16];
      2'd2:    b = dat[15:8];
      default: b = dat[7:0];
    endcase
    case (len)
      2'b00:   align_data = extend({8'h00, b}, 1'b1, sext);
      2'b01:   align_data = extend(off[1] ? dat[15:0] : dat[31:16], 1'b0, sext);
      default: align_data = dat;
    endcase
  endfunction

  assign misaligned = ((length_i == 2'b01) && addr_i[0]) ||
                      (length_i[1] && (addr_i[1:0] != 2'b00));
  assign resp       = dbus_ack_i | dbus_err_i;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    result_d = result_q;
    off_d    = off_q;
    len_d    = len_q;
    sext_d   = sext_q;
    valid_d  = 1'b0;
    align_d  = 1'b0;
    buserr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req_i && !flush_i) begin
          if (misaligned) begin
            align_d = 1'b1;
          end else begin
            adr_d   = {addr_i[W-1:2], 2'b00};
            off_d   = addr_i[1:0];
            len_d   = length_i;
            sext_d  = sext_i;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (resp) begin
          state_d = IDLE;
          // A flush coinciding with the response discards it silently.
          if (!flush_i) begin
            if (dbus_err_i) begin
              buserr_d = 1'b1;
            end else begin
              valid_d  = 1'b1;
              result_d = align_data(dbus_dat_i, off_q, len_q, sext_q);
            end
          end
        end else if (flush_i) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      result_q <= '0;
      off_q    <= 2'b00;
      len_q    <= 2'b00;
      sext_q   <= 1'b0;
      valid_q  <= 1'b0;
      align_q  <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      result_q <= result_d;
      off_q    <= off_d;
      len_q    <= len_d;
      sext_q   <= sext_d;
      valid_q  <= valid_d;
      align_q  <= align_d;
      buserr_q <= buserr_d;
    end
  end

  // An aborted read keeps requesting until the bus finishes the transfer.
  assign dbus_req_o      = (state_q != IDLE);
  assign busy_o          = (state_q != IDLE);
  assign dbus_adr_o      = adr_q;
  assign lsu_result_o    = result_q;
  assign lsu_valid_o     = valid_q;
  assign except_align_o  = align_q;
  assign except_buserr_o = buserr_q;

endmodule

// File: tb/tb_mor1kx_load_unit_cappuccino.sv
// Bench for the load unit: vector table plus scoreboard, and directed
// sequences for misalignment, bus error, flush and mid-read reset.
module tb_mor1kx_load_unit_cappuccino;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req_i;
  logic [31:0] addr_i;
  logic [1:0]  length_i;
  logic        sext_i;
  logic        flush_i;
  logic        dbus_req_o;
  logic [31:0] dbus_adr_o;
  logic        dbus_ack_i;
  logic        dbus_err_i;
  logic [31:0] dbus_dat_i;
  logic [31:0] lsu_result_o;
  logic        lsu_valid_o;
  logic        busy_o;
  logic        except_align_o;
  logic        except_buserr_o;

  mor1kx_load_unit_cappuccino #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load_req_i(load_req_i), .addr_i(addr_i),
    .length_i(length_i), .sext_i(sext_i), .flush_i(flush_i),
    .dbus_req_o(dbus_req_o), .dbus_adr_o(dbus_adr_o),
    .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i), .dbus_dat_i(dbus_dat_i),
    .lsu_result_o(lsu_result_o), .lsu_valid_o(lsu_valid_o), .busy_o(busy_o),
    .except_align_o(except_align_o), .except_buserr_o(except_buserr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  len;
    logic        sext;
    logic [31:0] dat;
    int          waits;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          vcnt  = 0;
  int          acnt  = 0;
  int          bcnt  = 0;
  int          excl  = 0;
  int          exp_v = 0;

  always @(negedge clk) begin
    if (lsu_valid_o)     vcnt++;
    if (except_align_o)  acnt++;
    if (except_buserr_o) bcnt++;
    if (int'(lsu_valid_o) + int'(except_align_o) + int'(except_buserr_o) > 1) excl++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] len,
                                        input logic s, input logic [31:0] d);
    logic [31:0] v;
    if (len == 2'b00) begin
      v = (d >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
      if (s && v[7]) v = v | 32'hFFFF_FF00;
    end else if (len == 2'b01) begin
      v = a[1] ? (d & 32'hFFFF) : (d >> 16);
      if (s && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic start_load(input logic [31:0] a, input logic [1:0] len, input logic s);
    load_req_i = 1'b1; addr_i = a; length_i = len; sext_i = s;
    @(posedge clk); #1;
    load_req_i = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] a, input logic [1:0] len, input logic s,
                          input logic [31:0] d, input int waits, input logic [31:0] exp);
    int reqc;
    exp_q.push_back(exp);
    exp_v++;
    start_load(a, len, s);
    chk("req_rise", 32'(dbus_req_o), 32'd1);
    chk("bus_adr", dbus_adr_o, {a[31:2], 2'b00});
    reqc = 1;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      if (dbus_req_o && dbus_adr_o == {a[31:2], 2'b00}) reqc++;
    end
    if (waits > 0) chk("req_held", 32'(reqc), 32'(waits + 1));
    dbus_ack_i = 1'b1; dbus_dat_i = d;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0; dbus_dat_i = $urandom;
    chk("valid", 32'(lsu_valid_o), 32'd1);
    chk("req_drop", 32'(dbus_req_o), 32'd0);
    if (lsu_valid_o && exp_q.size() > 0) chk("result", lsu_result_o, exp_q.pop_front());
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic [31:0] a, d;
    logic [1:0]  len;
    logic        s;
    int          v0;

    vecs[0] = '{32'h0000_1003, 2'b00, 1'b1, 32'h0000_00F0, 0, 32'hFFFF_FFF0};
    vecs[1] = '{32'h0000_2002, 2'b01, 1'b0, 32'h1234_ABCD, 3, 32'h0000_ABCD};
    vecs[2] = '{32'h0000_1000, 2'b00, 1'b0, 32'h8011_2233, 0, 32'h0000_0080};
    vecs[3] = '{32'h0000_1001, 2'b00, 1'b1, 32'h0080_0000, 1, 32'hFFFF_FF80};
    vecs[4] = '{32'h0000_2000, 2'b01, 1'b1, 32'h8001_7FFF, 0, 32'hFFFF_8001};
    vecs[5] = '{32'h0000_3000, 2'b10, 1'b1, 32'h1122_3344, 2, 32'h1122_3344};
    vecs[6] = '{32'h0000_3004, 2'b11, 1'b0, 32'hCAFE_BABE, 0, 32'hCAFE_BABE};
    vecs[7] = '{32'h0000_1002, 2'b00, 1'b1, 32'h0000_7F00, 0, 32'h0000_007F};

    rst = 1'b0; load_req_i = 1'b0; addr_i = '0; length_i = '0; sext_i = 1'b0;
    flush_i = 1'b0; dbus_ack_i = 1'b0; dbus_err_i = 1'b0; dbus_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dbus_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_adr", dbus_adr_o, 32'd0);
    chk("rst_result", lsu_result_o, 32'd0);
    chk("rst_pulses", {29'd0, lsu_valid_o, except_align_o, except_buserr_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors run back-to-back: each new request lands in the valid cycle.
    for (int i = 0; i < 8; i++)
      run_load(vecs[i].addr, vecs[i].len, vecs[i].sext, vecs[i].dat, vecs[i].waits, vecs[i].exp);
    chk("idle_after", 32'(busy_o), 32'd0);

    for (int i = 0; i < 16; i++) begin
      len = 2'($urandom_range(0, 3));
      a   = 32'h0001_0000 | ($urandom & 32'hFFFC);
      if (len == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      if (len == 2'b01) a[1]   = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      d = $urandom;
      run_load(a, len, s, d, $urandom_range(0, 2), model(a, len, s, d));
    end

    // Misaligned word and half: one align pulse each, no bus activity.
    held = lsu_result_o;
    start_load(32'h0000_3001, 2'b10, 1'b0);
    chk("align_word", 32'(except_align_o), 32'd1);
    chk("align_noreq", 32'(dbus_req_o), 32'd0);
    chk("align_busy", 32'(busy_o), 32'd0);
    start_load(32'h0000_2001, 2'b01, 1'b1);
    chk("align_half", 32'(except_align_o), 32'd1);
    @(posedge clk); #1;
    chk("align_once", 32'(except_align_o), 32'd0);
    chk("align_keep", lsu_result_o, held);

    // Ack and err together count as a bus error.
    start_load(32'h0000_3000, 2'b10, 1'b0);
    dbus_ack_i = 1'b1; dbus_err_i = 1'b1; dbus_dat_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
    chk("err_pulse", 32'(except_buserr_o), 32'd1);
    chk("err_novalid", 32'(lsu_valid_o), 32'd0);
    chk("err_keep", lsu_result_o, held);
    chk("err_idle", 32'(busy_o), 32'd0);

    // Flush one cycle into READ, ack two cycles later.
    v0 = vcnt;
    start_load(32'h0000_5000, 2'b10, 1'b0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd1);
    chk("abort_req", 32'(dbus_req_o), 32'd1);
    @(posedge clk); #1;
    chk("abort_wait", 32'(busy_o), 32'd1);
    dbus_ack_i = 1'b1; dbus_dat_i = 32'h5555_5555;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    chk("abort_done", 32'(busy_o), 32'd0);
    chk("abort_nopulse", {29'd0, lsu_valid_o, except_align_o, except_buserr_o}, 32'd0);
    chk("abort_keep", lsu_result_o, held);
    run_load(32'h0000_5004, 2'b10, 1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D);
    held = lsu_result_o;

    // Flush with ack in the same READ cycle discards the data.
    start_load(32'h0000_6000, 2'b10, 1'b0);
    flush_i = 1'b1; dbus_ack_i = 1'b1; dbus_dat_i = 32'h7777_7777;
    @(posedge clk); #1;
    flush_i = 1'b0; dbus_ack_i = 1'b0;
    chk("flushack_idle", 32'(busy_o), 32'd0);
    chk("flushack_nopulse", {29'd0, lsu_valid_o, except_align_o, except_buserr_o}, 32'd0);
    chk("flushack_keep", lsu_result_o, held);

    // Flush beats a request in IDLE, even a misaligned one.
    flush_i = 1'b1;
    start_load(32'h0000_7001, 2'b10, 1'b0);
    flush_i = 1'b0;
    chk("flushreq_busy", 32'(busy_o), 32'd0);
    chk("flushreq_noalign", 32'(except_align_o), 32'd0);
    chk("pulse_total_pre", 32'(vcnt - v0), 32'd1);

    // Reset in the middle of a read, then a stray ack after release.
    start_load(32'h0000_4000, 2'b10, 1'b0);
    chk("rr_busy", 32'(busy_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rr_req", 32'(dbus_req_o), 32'd0);
    chk("rr_busy0", 32'(busy_o), 32'd0);
    chk("rr_adr", dbus_adr_o, 32'd0);
    chk("rr_result", lsu_result_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    v0 = vcnt;
    dbus_ack_i = 1'b1; dbus_dat_i = 32'h1234_5678;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    chk("rr_novalid", 32'(lsu_valid_o), 32'd0);
    chk("rr_idle", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    chk("rr_nopulse", 32'(vcnt - v0), 32'd0);

    chk("valid_count", 32'(vcnt), 32'(exp_v));
    chk("align_count", 32'(acnt), 32'd2);
    chk("buserr_count", 32'(bcnt), 32'd1);
    chk("exclusive", 32'(excl), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
